// File: rtl/writeback_unit.sv
// Writeback arbiter: merges single-cycle ALU results with an in-order load-result
// queue into one registered register-file write port, and tracks outstanding loads.
module writeback_unit #(
  parameter int LQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  input  logic [4:0]         alu_rd,
  input  logic signed [31:0] alu_data,
  output logic               alu_stall,
  input  logic               iss_valid,
  input  logic [4:0]         iss_rd,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [4:0]         ld_rd,
  input  logic signed [31:0] ld_data,
  output logic               reg_Write,
  output logic [4:0]         wb_rd,
  output logic signed [31:0] write_date,
  output logic [31:0]        busy
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

  logic [4:0]    q_rd_q   [LQ_DEPTH];
  logic [31:0]   q_data_q [LQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   busy_q, busy_d;

  logic          full, empty, push, pop, alu_win, commit;
  logic [4:0]    head_rd, sel_rd;
  logic [31:0]   head_data, sel_data, set_mask, clr_mask;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign head_rd   = q_rd_q[rd_ptr_q];
  assign head_data = q_data_q[rd_ptr_q];
  assign ld_ready  = !full;
  assign push      = ld_valid && !full;
  assign alu_stall = alu_valid && ((busy_q[alu_rd] && (alu_rd != 5'd0)) || full);

  // A full queue always drains first so loads cannot be starved by an ALU stream.
  always_comb begin
    alu_win = 1'b0;
    pop     = 1'b0;
    if (full) begin
      pop = 1'b1;
    end else if (alu_valid && !busy_q[alu_rd]) begin
      alu_win = 1'b1;
    end else if (!empty) begin
      pop = 1'b1;
    end
    commit   = alu_win || pop;
    sel_rd   = pop ? head_rd : alu_rd;
    sel_data = pop ? head_data : alu_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // x0 commits still consume their source but never assert the write enable.
  always_comb begin
    we_d    = commit && (sel_rd != 5'd0);
    wb_rd_d = commit ? sel_rd : wb_rd_q;
    data_d  = commit ? sel_data : data_q;
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && (iss_rd != 5'd0)) set_mask = 32'd1 << iss_rd;
    if (pop) clr_mask = 32'd1 << head_rd;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd_q[wr_ptr_q]   <= ld_rd;
      q_data_q[wr_ptr_q] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wb_rd_q  <= '0;
      data_q   <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wb_rd_q  <= wb_rd_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  assign reg_Write  = we_q;
  assign wb_rd      = wb_rd_q;
  assign write_date = data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (default queue depth of 2).
module tb_writeback_unit;

  logic               clk;
  logic               rst;
  logic               alu_valid;
  logic [4:0]         alu_rd;
  logic signed [31:0] alu_data;
  logic               alu_stall;
  logic               iss_valid;
  logic [4:0]         iss_rd;
  logic               ld_valid;
  logic               ld_ready;
  logic [4:0]         ld_rd;
  logic signed [31:0] ld_data;
  logic               reg_Write;
  logic [4:0]         wb_rd;
  logic signed [31:0] write_date;
  logic [31:0]        busy;

  int errors = 0;
  int checks = 0;

  writeback_unit #(.LQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .reg_Write(reg_Write), .wb_rd(wb_rd), .write_date(write_date), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #2;
    checks++; if (reg_Write !== 1'b0) begin errors++; $display("FAIL rst_we got %0b want 0", reg_Write); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0d want 0", wb_rd); end
    checks++; if (write_date !== 32'd0) begin errors++; $display("FAIL rst_data got %h want 0", write_date); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL rst_busy got %h want 0", busy); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", ld_ready); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (reg_Write !== 1'b0) begin errors++; $display("FAIL rst_rel_we got %0b want 0", reg_Write); end
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h12345678;
    #1;
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b want 0", alu_stall); end
    tick();
    alu_valid = 1'b0;
    checks++; if (reg_Write !== 1'b1) begin errors++; $display("FAIL alu_we got %0b want 1", reg_Write); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d want 5", wb_rd); end
    checks++; if (write_date !== 32'h12345678) begin errors++; $display("FAIL alu_data got %h want 12345678", write_date); end
    tick();
    checks++; if (reg_Write !== 1'b0) begin errors++; $display("FAIL idle_we got %0b want 0", reg_Write); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL idle_rd_hold got %0d want 5", wb_rd); end
    checks++; if (write_date !== 32'h12345678) begin errors++; $display("FAIL idle_data_hold got %h want 12345678", write_date); end
  endtask

  task automatic test_load();
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL ld_busy_set got %h want 00000080", busy); end
    tick();
    tick();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = -32'sd1;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready got %0b want 1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    checks++; if (reg_Write !== 1'b0) begin errors++; $display("FAIL ld_min_latency_we got %0b want 0", reg_Write); end
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL ld_busy_pending got %h want 00000080", busy); end
    tick();
    checks++; if (reg_Write !== 1'b1) begin errors++; $display("FAIL ld_we got %0b want 1", reg_Write); end
    checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL ld_rd got %0d want 7", wb_rd); end
    checks++; if (write_date !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ld_data got %h want ffffffff", write_date); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL ld_busy_clr got %h want 0", busy); end
  endtask

  task automatic test_waw();
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_AAAA;
    #1;
    checks++; if (alu_stall !== 1'b1) begin errors++; $display("FAIL waw_stall0 got %0b want 1", alu_stall); end
    tick();
    checks++; if (reg_Write !== 1'b0) begin errors++; $display("FAIL waw_no_write got %0b want 0", reg_Write); end
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0099;
    tick();
    ld_valid = 1'b0;
    checks++; if (alu_stall !== 1'b1) begin errors++; $display("FAIL waw_stall1 got %0b want 1", alu_stall); end
    tick();
    checks++; if (reg_Write !== 1'b1 || wb_rd !== 5'd9 || write_date !== 32'h99)
      begin errors++; $display("FAIL waw_ld_commit got we=%0b rd=%0d data=%h want 1/9/99", reg_Write, wb_rd, write_date); end
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL waw_release got %0b want 0", alu_stall); end
    tick();
    alu_valid = 1'b0;
    checks++; if (reg_Write !== 1'b1 || wb_rd !== 5'd9 || write_date !== 32'hAAAA)
      begin errors++; $display("FAIL waw_alu_commit got we=%0b rd=%0d data=%h want 1/9/aaaa", reg_Write, wb_rd, write_date); end
    tick();
  endtask

  task automatic test_full();
    iss_valid = 1'b1; iss_rd = 5'd10;
    tick();
    iss_rd = 5'd11;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h100;
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h10;
    tick();
    checks++; if (reg_Write !== 1'b1 || wb_rd !== 5'd12) begin errors++; $display("FAIL full_alu0 got we=%0b rd=%0d want 1/12", reg_Write, wb_rd); end
    alu_rd = 5'd13; alu_data = 32'h101;
    ld_rd = 5'd11; ld_data = 32'h11;
    #1;
    checks++; if (alu_stall !== 1'b0 || ld_ready !== 1'b1) begin errors++; $display("FAIL full_half got stall=%0b ready=%0b want 0/1", alu_stall, ld_ready); end
    tick();
    ld_rd = 5'd14; ld_data = 32'h14;
    #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", ld_ready); end
    checks++; if (alu_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %0b want 1", alu_stall); end
    tick();
    ld_valid = 1'b0;
    checks++; if (reg_Write !== 1'b1 || wb_rd !== 5'd10 || write_date !== 32'h10)
      begin errors++; $display("FAIL full_head got we=%0b rd=%0d data=%h want 1/10/10", reg_Write, wb_rd, write_date); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %0b want 1", ld_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (reg_Write !== 1'b1 || wb_rd !== 5'd13 || write_date !== 32'h101)
      begin errors++; $display("FAIL full_alu1 got we=%0b rd=%0d data=%h want 1/13/101", reg_Write, wb_rd, write_date); end
    tick();
    checks++; if (reg_Write !== 1'b1 || wb_rd !== 5'd11 || write_date !== 32'h11)
      begin errors++; $display("FAIL full_second got we=%0b rd=%0d data=%h want 1/11/11", reg_Write, wb_rd, write_date); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL full_busy got %h want 0", busy); end
    tick();
    checks++; if (reg_Write !== 1'b0) begin errors++; $display("FAIL full_no_third got %0b want 0", reg_Write); end
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    #1;
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %0b want 0", alu_stall); end
    tick();
    alu_valid = 1'b0;
    checks++; if (reg_Write !== 1'b0) begin errors++; $display("FAIL x0_we got %0b want 0", reg_Write); end
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x0_busy got %h want 0", busy); end
    iss_rd = 5'd3;
    tick();
    iss_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
    tick();
    ld_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    iss_valid = 1'b0;
    checks++; if (reg_Write !== 1'b1 || wb_rd !== 5'd3) begin errors++; $display("FAIL x3_commit got we=%0b rd=%0d want 1/3", reg_Write, wb_rd); end
    checks++; if (busy !== 32'h8) begin errors++; $display("FAIL set_wins got %h want 00000008", busy); end
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h34;
    tick();
    ld_valid = 1'b0;
    tick();
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x3_clear got %h want 0", busy); end
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_rd = 5'd20;
    tick();
    iss_rd = 5'd21;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 32'h1;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h20;
    tick();
    ld_rd = 5'd21; ld_data = 32'h21;
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %0b want 0", ld_ready); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (reg_Write !== 1'b0 || wb_rd !== 5'd0 || write_date !== 32'd0)
      begin errors++; $display("FAIL mid_outputs got we=%0b rd=%0d data=%h want 0/0/0", reg_Write, wb_rd, write_date); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL mid_busy got %h want 0", busy); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b want 1", ld_ready); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (reg_Write !== 1'b0) begin errors++; $display("FAIL mid_stale0 got %0b want 0", reg_Write); end
    tick();
    checks++; if (reg_Write !== 1'b0 || busy !== 32'd0) begin errors++; $display("FAIL mid_stale1 got we=%0b busy=%h want 0/0", reg_Write, busy); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_waw();
    test_full();
    test_x0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
